// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage with IF/ID register and skid buffer
//
// Purpose: holds the PC and issues single-outstanding word fetches over a
// req/ack bus. Returned words are placed in the IF/ID register, or in a
// one-entry skid buffer when IF/ID is full and stalled. Execute-stage
// redirects flush everything already fetched. An outstanding request is
// never abandoned: its ack is drained in DROP and then discarded.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   imem_req_o     fetch request, held until imem_ack_i
//   imem_addr_o    fetch word address, stable while imem_req_o
//   imem_ack_i     response valid (same cycle as request or later)
//   imem_rdata_i   instruction word, valid with imem_ack_i
//   redirect_i     execute-stage PC override, flushes fetched words
//   redirect_pc_i  redirect target
//   stall_i        hold IF/ID contents
//   id_valid_o     IF/ID holds a live instruction
//   id_instr_o     IF/ID instruction (NOP 32'h13 when invalid)
//   id_pc_o        PC of id_instr_o
//   id_pc_plus4_o  id_pc_o + 4, registered link value
//   id_fault_o     misaligned-target fault (FETCH_MISALIGN_TRAP_EN only)
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When defined, a redirect
// to a non-word-aligned target reports a fault in IF/ID and halts fetch
// until the next aligned redirect. When undefined, the target's low two
// bits are forced to zero.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        id_fault_o
`endif
);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_DROP = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0]  S_HALT = 2'd3;
`endif

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  logic [31:0] w_target;
  logic        w_misalign;
  logic        w_accept;
  logic        w_id_adv;
  logic        w_skid_valid_nxt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        r_id_fault;
  logic        r_halt_pend;
  logic        w_halt_req;

  assign w_target   = redirect_pc_i;
  assign w_misalign = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  // In DROP, the most recent redirect decides whether the drained ack
  // leads to HALT or to a fresh fetch.
  assign w_halt_req = redirect_i ? w_misalign : r_halt_pend;
  assign id_fault_o = r_id_fault;
`else
  assign w_target   = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_misalign = 1'b0;
`endif

  // A word is accepted only for a live (non-stale) request that is not
  // being overridden by a redirect in the same cycle.
  assign w_accept = (r_state == S_WAIT) && imem_ack_i && !redirect_i;
  // IF/ID may load when it is empty or decode is taking its contents.
  assign w_id_adv = !stall_i || !r_id_valid;

  always_comb begin
    w_skid_valid_nxt = 1'b0;
    if (redirect_i) begin
      w_skid_valid_nxt = 1'b0;
    end else if (!w_id_adv) begin
      w_skid_valid_nxt = r_skid_valid || w_accept;
    end
  end

  // Fetch continues only once the skid buffer will be empty, which keeps
  // at most one word in flight beyond IF/ID.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (w_misalign) begin
          w_state_nxt = S_HALT;
        end else
`endif
        if (!w_skid_valid_nxt) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          if (!imem_ack_i) begin
            w_state_nxt = S_DROP;
          end
`ifdef FETCH_MISALIGN_TRAP_EN
          else if (w_misalign) begin
            w_state_nxt = S_HALT;
          end
`endif
          else begin
            w_state_nxt = S_WAIT;
          end
        end else if (imem_ack_i) begin
          w_state_nxt = w_skid_valid_nxt ? S_IDLE : S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_ack_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          w_state_nxt = w_halt_req ? S_HALT : S_WAIT;
`else
          w_state_nxt = S_WAIT;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_HALT: begin
        if (redirect_i && !w_misalign) begin
          w_state_nxt = S_WAIT;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drop_addr  <= 32'h0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= 32'h0;
      r_skid_pc    <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (redirect_i) begin
        r_pc <= w_target;
      end else if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end
      // The abandoned request keeps its address on the bus until its ack.
      if (r_state == S_WAIT && redirect_i && !imem_ack_i) begin
        r_drop_addr <= r_pc;
      end
      if (!redirect_i && !w_id_adv && w_accept) begin
        r_skid_instr <= imem_rdata_i;
        r_skid_pc    <= r_pc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP;
      r_id_pc    <= 32'h0;
      r_id_pc4   <= 32'h4;
    end else if (redirect_i) begin
      // Flush; with the trap enabled a misaligned target becomes a
      // faulting NOP tagged with the offending address.
      r_id_valid <= w_misalign;
      r_id_instr <= NOP;
      r_id_pc    <= w_target;
      r_id_pc4   <= w_target + 32'd4;
    end else if (w_id_adv) begin
      if (r_skid_valid) begin
        r_id_valid <= 1'b1;
        r_id_instr <= r_skid_instr;
        r_id_pc    <= r_skid_pc;
        r_id_pc4   <= r_skid_pc + 32'd4;
      end else if (w_accept) begin
        r_id_valid <= 1'b1;
        r_id_instr <= imem_rdata_i;
        r_id_pc    <= r_pc;
        r_id_pc4   <= r_pc + 32'd4;
      end else begin
        r_id_valid <= 1'b0;
        r_id_instr <= NOP;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id_fault  <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      if (redirect_i) begin
        r_id_fault  <= w_misalign;
        r_halt_pend <= w_misalign;
      end else if (w_id_adv) begin
        r_id_fault <= 1'b0;
      end
    end
  end
`endif

  assign imem_req_o    = (r_state == S_WAIT) || (r_state == S_DROP);
  assign imem_addr_o   = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign id_valid_o    = r_id_valid;
  assign id_instr_o    = r_id_instr;
  assign id_pc_o       = r_id_pc;
  assign id_pc_plus4_o = r_id_pc4;

endmodule
